// File: rtl/mux_4to1_pkg.sv
// mux_4to1_pkg
// Shared constants for the mux_4to1 selector block.
//   MUX_SEL4_W     : width of the 4:1 select
//   SEL_IN0..3     : named 4:1 select values (slice index of d)
package mux_4to1_pkg;

  localparam int MUX_SEL4_W = 2;

  localparam logic [MUX_SEL4_W-1:0] SEL_IN0 = 2'd0;
  localparam logic [MUX_SEL4_W-1:0] SEL_IN1 = 2'd1;
  localparam logic [MUX_SEL4_W-1:0] SEL_IN2 = 2'd2;
  localparam logic [MUX_SEL4_W-1:0] SEL_IN3 = 2'd3;

endpackage

// File: rtl/mux_2to1.sv
// mux_2to1
// Purely combinational 2:1 selector cell used to build both paths of mux_4to1.
// Ports:
//   a   in  WIDTH  input 0
//   b   in  WIDTH  input 1
//   sel in  1      select (0 -> a, 1 -> b)
//   y   out WIDTH  selected value
module mux_2to1 #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);

  // select between the two inputs
  always_comb begin
    y = a;
    if (sel) begin
      y = b;
    end else begin
      y = a;
    end
  end

endmodule

// File: rtl/mux_4to1.sv
// mux_4to1
// Side-by-side 2:1 and 4:1 selectors, each WIDTH bits wide. The 4:1 path is a
// two-level tree of mux_2to1 cells. With macro MUX_OUT_REG_EN defined, both
// results pass through one registered stage (latency 1, load on in_valid,
// hold otherwise) with a valid flag; without it the block is combinational
// and clk/rst are unused.
// Ports:
//   clk       in  1          rising-edge clock
//   rst       in  1          synchronous active-high reset
//   in_valid  in  1          qualifies the current inputs
//   a, b      in  WIDTH      2:1 inputs
//   sel2      in  1          2:1 select
//   d         in  4*WIDTH    4:1 inputs, slice i = d[i*WIDTH +: WIDTH]
//   sel4      in  2          4:1 select
//   y2        out WIDTH      2:1 result
//   y4        out WIDTH      4:1 result
//   out_valid out  1         y2/y4 hold a result from a valid input
module mux_4to1
  import mux_4to1_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [WIDTH-1:0]      a,
  input  logic [WIDTH-1:0]      b,
  input  logic                  sel2,
  input  logic [4*WIDTH-1:0]    d,
  input  logic [MUX_SEL4_W-1:0] sel4,
  output logic [WIDTH-1:0]      y2,
  output logic [WIDTH-1:0]      y4,
  output logic                  out_valid
);

  logic [WIDTH-1:0] y2_s;
  logic [WIDTH-1:0] lo_s;
  logic [WIDTH-1:0] hi_s;
  logic [WIDTH-1:0] y4_s;

  mux_2to1 #(.WIDTH(WIDTH)) u_mux2 (
    .a(a), .b(b), .sel(sel2), .y(y2_s)
  );

  // Level 1: sel4[0] picks within the low pair and within the high pair
  mux_2to1 #(.WIDTH(WIDTH)) u_l1_lo (
    .a(d[0*WIDTH +: WIDTH]), .b(d[1*WIDTH +: WIDTH]), .sel(sel4[0]), .y(lo_s)
  );
  mux_2to1 #(.WIDTH(WIDTH)) u_l1_hi (
    .a(d[2*WIDTH +: WIDTH]), .b(d[3*WIDTH +: WIDTH]), .sel(sel4[0]), .y(hi_s)
  );

  // Level 2: sel4[1] picks between the two pairs
  mux_2to1 #(.WIDTH(WIDTH)) u_l2 (
    .a(lo_s), .b(hi_s), .sel(sel4[1]), .y(y4_s)
  );

`ifdef MUX_OUT_REG_EN
  logic [WIDTH-1:0] y2_r;
  logic [WIDTH-1:0] y4_r;
  logic             out_valid_r;

  // output stage: reset wins, a valid input loads, otherwise data holds
  always_ff @(posedge clk) begin
    if (rst) begin
      y2_r        <= '0;
      y4_r        <= '0;
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= in_valid;
      if (in_valid) begin
        y2_r <= y2_s;
        y4_r <= y4_s;
      end else begin
        y2_r <= y2_r;
        y4_r <= y4_r;
      end
    end
  end

  assign y2        = y2_r;
  assign y4        = y4_r;
  assign out_valid = out_valid_r;
`else
  // clk/rst stay on the port list for a uniform interface; tie them off here
  logic unused_clk_rst_s;
  assign unused_clk_rst_s = &{1'b0, clk, rst};

  assign y2        = y2_s;
  assign y4        = y4_s;
  assign out_valid = in_valid;
`endif

endmodule

// File: tb/tb_mux_4to1.sv
// tb_mux_4to1
// Self-checking bench for mux_4to1 at WIDTH=8 and WIDTH=1 side by side.
// Expected values come from a slice-indexing reference model; the bench
// follows the registered or combinational build through MUX_OUT_REG_EN.
module tb_mux_4to1;
  import mux_4to1_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  a8 = 8'h00;
  logic [7:0]  b8 = 8'h00;
  logic        sel2 = 1'b0;
  logic [31:0] d8 = 32'h0;
  logic [3:0]  d1 = 4'h0;
  logic [1:0]  sel4 = 2'd0;

  logic [7:0] y2_8, y4_8;
  logic       ov8;
  logic [0:0] y2_1, y4_1;
  logic       ov1;

  int compared = 0;
  int mismatched = 0;

  // reference expectations
  logic [7:0] exp_y2_8, exp_y4_8;
  logic       exp_y2_1, exp_y4_1, exp_v;

  always #5 clk = ~clk;

  mux_4to1 #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .a(a8), .b(b8), .sel2(sel2), .d(d8), .sel4(sel4),
    .y2(y2_8), .y4(y4_8), .out_valid(ov8)
  );

  mux_4to1 #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .a(a8[0:0]), .b(b8[0:0]), .sel2(sel2), .d(d1), .sel4(sel4),
    .y2(y2_1), .y4(y4_1), .out_valid(ov1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // selection rules evaluated from the current inputs
  function automatic logic [7:0] ref_y2_8();
    return sel2 ? b8 : a8;
  endfunction
  function automatic logic [7:0] ref_y4_8();
    logic [31:0] t;
    t = d8 >> (8 * int'(sel4));
    return t[7:0];
  endfunction
  function automatic logic ref_y2_1();
    return sel2 ? b8[0] : a8[0];
  endfunction
  function automatic logic ref_y4_1();
    return d1[sel4];
  endfunction

  task automatic compare_all(input string tag);
    check({tag, ".y2_8"}, {24'h0, y2_8}, {24'h0, exp_y2_8});
    check({tag, ".y4_8"}, {24'h0, y4_8}, {24'h0, exp_y4_8});
    check({tag, ".ov8"},  {31'h0, ov8},  {31'h0, exp_v});
    check({tag, ".y2_1"}, {31'h0, y2_1}, {31'h0, exp_y2_1});
    check({tag, ".y4_1"}, {31'h0, y4_1}, {31'h0, exp_y4_1});
    check({tag, ".ov1"},  {31'h0, ov1},  {31'h0, exp_v});
  endtask

  // Drive one cycle of inputs and check outputs at the point they are defined.
  task automatic step(input string tag, input logic r, input logic v,
                      input logic [7:0] ia, input logic [7:0] ib, input logic s2,
                      input logic [31:0] id8, input logic [3:0] id1, input logic [1:0] s4);
    @(negedge clk);
    rst = r; in_valid = v; a8 = ia; b8 = ib; sel2 = s2;
    d8 = id8; d1 = id1; sel4 = s4;
`ifdef MUX_OUT_REG_EN
    @(posedge clk);
    if (r) begin
      exp_y2_8 = 8'h00; exp_y4_8 = 8'h00; exp_y2_1 = 1'b0; exp_y4_1 = 1'b0;
      exp_v = 1'b0;
    end else begin
      exp_v = v;
      if (v) begin
        exp_y2_8 = ref_y2_8(); exp_y4_8 = ref_y4_8();
        exp_y2_1 = ref_y2_1(); exp_y4_1 = ref_y4_1();
      end
    end
    #1;
    compare_all(tag);
`else
    #1;
    exp_y2_8 = ref_y2_8(); exp_y4_8 = ref_y4_8();
    exp_y2_1 = ref_y2_1(); exp_y4_1 = ref_y4_1();
    exp_v = v;
    compare_all(tag);
`endif
  endtask

  initial begin
    exp_y2_8 = 8'h00; exp_y4_8 = 8'h00; exp_y2_1 = 1'b0; exp_y4_1 = 1'b0;
    exp_v = 1'b0;

    // reset state
    step("reset", 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 32'h0, 4'h0, SEL_IN0);

    // 2:1 path, WIDTH=1 values a=0 b=1
    step("sel2_0", 1'b0, 1'b1, 8'h00, 8'h01, 1'b0, 32'h0, 4'ha, SEL_IN0);
    step("sel2_1", 1'b0, 1'b1, 8'h00, 8'h01, 1'b1, 32'h0, 4'ha, SEL_IN0);

    // 4:1 sweep with d1=1010 and a distinct 8-bit pattern
    step("sel4_0", 1'b0, 1'b1, 8'h00, 8'h01, 1'b0, 32'hDDCCBBAA, 4'ha, SEL_IN0);
    step("sel4_1", 1'b0, 1'b1, 8'h00, 8'h01, 1'b0, 32'hDDCCBBAA, 4'ha, SEL_IN1);
    step("sel4_2", 1'b0, 1'b1, 8'h00, 8'h01, 1'b0, 32'hDDCCBBAA, 4'ha, SEL_IN2);
    step("sel4_3", 1'b0, 1'b1, 8'h00, 8'h01, 1'b0, 32'hDDCCBBAA, 4'ha, SEL_IN3);

    // WIDTH=8 directed: y4=CC, then y2=34
    step("w8_y4", 1'b0, 1'b1, 8'h12, 8'h34, 1'b1, 32'hDDCCBBAA, 4'h5, SEL_IN2);

    // hold: drop in_valid and change every input
    step("hold_a", 1'b0, 1'b0, 8'hFF, 8'h00, 1'b0, 32'h11223344, 4'h6, SEL_IN3);
    step("hold_b", 1'b0, 1'b0, 8'h5A, 8'hA5, 1'b1, 32'h99887766, 4'h9, SEL_IN1);

    // reset together with in_valid, then release
    step("rst_v", 1'b1, 1'b1, 8'h77, 8'h88, 1'b1, 32'hCAFEF00D, 4'hf, SEL_IN3);
    step("post_rst", 1'b0, 1'b1, 8'h77, 8'h88, 1'b1, 32'hCAFEF00D, 4'hf, SEL_IN3);

    // randomized traffic with occasional reset and idle cycles
    for (int i = 0; i < 300; i++) begin
      step("rand",
           ($urandom_range(15, 0) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(3, 0) != 0) ? 1'b1 : 1'b0,
           8'($urandom), 8'($urandom), 1'($urandom),
           32'($urandom), 4'($urandom), 2'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
